regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter AW, default 5, register address width; depth = 2**AW.
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 wen0  input  1  write enable, port 0 (ALU writeback).
REQ-007 waddr0  input  AW  write address, port 0.
REQ-008 wdata0  input  DW  write data, port 0.
REQ-009 wen1  input  1  write enable, port 1 (load writeback).
REQ-010 waddr1  input  AW  write address, port 1.
REQ-011 wdata1  input  DW  write data, port 1.
REQ-012 raddr  input  NRD*AW  packed read addresses; port k at bits [k*AW +: AW].
REQ-013 rdata  output  NRD*DW  packed read data; port k at bits [k*DW +: DW].
REQ-014 rbusy  output  NRD  per-read-port pending-write flag.
REQ-015 bset  input  1  mark a destination as pending (load issued).
REQ-016 baddr  input  AW  register marked pending by bset.
REQ-017 any_busy  output  1  OR of all pending bits.

Function
REQ-018 Register 0 reads as 0 on every port; writes and bset to address 0 are ignored (no storage update, no busy bit).
REQ-019 A write with wenX=1 and waddrX!=0 updates the register at the next rising edge.
REQ-020 When wen0 and wen1 target the same nonzero address in one cycle, port 1 data is stored; port 0 is dropped.
REQ-021 Reads are combinational, with write-first bypass: if raddr port k equals an address being written this cycle (nonzero), rdata port k shows that write data (port 1 over port 0); otherwise the stored value.
REQ-022 Scoreboard: one busy bit per register; bset=1 sets busy[baddr] at the next edge.
REQ-023 Write on either port to address A clears busy[A] at the next edge.
REQ-024 bset to A and write to A in the same cycle: busy[A] ends set (new issue wins over old retire).
REQ-025 rbusy[k] = busy[raddr_k] AND NOT (write to raddr_k this cycle); always 0 for address 0.
REQ-026 any_busy reflects the registered busy vector only (no bypass).
REQ-027 Read latency 0 cycles; write-to-storage latency 1 cycle; write-to-read latency 0 cycles via bypass.
REQ-028 No X on outputs for any input combination after the first reset edge.

Reset
REQ-029 rst_n=0 at a rising edge clears all registers to 0 and all busy bits to 0; reset dominates wen0, wen1 and bset in that cycle.
REQ-030 While rst_n=0, rdata bypass is suppressed: rdata returns stored values (0 after the first reset edge), rbusy=0 and any_busy=0.
REQ-031 Reset mid-operation discards any pending writes and busy marks issued in the same cycle; the first post-reset edge behaves normally.

Structure
REQ-032 Shared package regfile_pkg holds default DW/AW/NRD constants and the address-zero constant REG_ZERO.
REQ-033 One sub-module, regfile_scoreboard, holds the busy vector, set/clear priority and any_busy; storage and bypass stay in regfile_sb.
REQ-034 Read ports are generated by a loop over NRD; no per-port hand-copied logic.

Verification
REQ-035 Reset, then read all 32 addresses on both ports -> all rdata=0, rbusy=0, any_busy=0.
REQ-036 wen0=1 waddr0=5 wdata0=0x1234_5678 with raddr port0=5 in the same cycle -> rdata0=0x1234_5678 that cycle and on every later cycle.
REQ-037 wen0/wen1 both to 7, wdata0=0xAAAA_AAAA, wdata1=0x5555_5555 -> same-cycle read and next-cycle read of 7 both 0x5555_5555.
REQ-038 wen1=1 waddr1=0 wdata1=0xFFFF_FFFF, bset baddr=0 -> rdata for address 0 stays 0, any_busy=0.
REQ-039 bset baddr=9; next cycle rbusy for raddr=9 is 1 and any_busy=1; then wen1 waddr1=9 -> rbusy=0 same cycle; next cycle busy[9]=0 and any_busy=0; repeat with bset and wen1 to 9 together -> busy[9] remains 1.
REQ-040 Write 0xDEAD_BEEF to 3 and bset 4; next cycle assert rst_n=0 together with wen0 to 3 -> after edge read 3 = 0, busy[4]=0, any_busy=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register file with pending-write scoreboard.
package regfile_pkg;
    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int NRD_DEF  = 2;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: set by a load issue, cleared by a writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bset,
    input  logic [AW-1:0]     baddr,
    input  logic              clr0,
    input  logic [AW-1:0]     caddr0,
    input  logic              clr1,
    input  logic [AW-1:0]     caddr1,
    output logic [2**AW-1:0]  busy,
    output logic              any_busy
);

    logic [2**AW-1:0] busy_nxt;

    // Set is applied after the clears so a new issue beats an old retire.
    always_comb begin
        busy_nxt = busy;
        if (clr0) busy_nxt[caddr0] = 1'b0;
        if (clr1) busy_nxt[caddr1] = 1'b0;
        if (bset && (baddr != AW'(REG_ZERO))) busy_nxt[baddr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign any_busy = rst_n & (|busy);

endmodule

// File: rtl/regfile_sb.sv
// Two-write, NRD-read register file with write-first bypass and load scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int NRD = NRD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen0,
    input  logic [AW-1:0]     waddr0,
    input  logic [DW-1:0]     wdata0,
    input  logic              wen1,
    input  logic [AW-1:0]     waddr1,
    input  logic [DW-1:0]     wdata1,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              bset,
    input  logic [AW-1:0]     baddr,
    output logic              any_busy
);

    logic [DW-1:0]    mem [2**AW];
    logic [2**AW-1:0] busy;
    logic             we0;
    logic             we1;

    assign we0 = wen0 && (waddr0 != AW'(REG_ZERO));
    assign we1 = wen1 && (waddr1 != AW'(REG_ZERO));

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else begin
            if (we0) mem[waddr0] <= wdata0;
            if (we1) mem[waddr1] <= wdata1;
        end
    end

    regfile_scoreboard #(.AW(AW)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .bset     (bset),
        .baddr    (baddr),
        .clr0     (we0),
        .caddr0   (waddr0),
        .clr1     (we1),
        .caddr1   (waddr1),
        .busy     (busy),
        .any_busy (any_busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit0;
        logic          hit1;
        logic [DW-1:0] rd;

        assign ra   = raddr[k*AW +: AW];
        assign hit0 = rst_n && we0 && (waddr0 == ra);
        assign hit1 = rst_n && we1 && (waddr1 == ra);

        always_comb begin
            rd = mem[ra];
            if (ra == AW'(REG_ZERO)) rd = '0;
            else if (hit1)           rd = wdata1;
            else if (hit0)           rd = wdata0;
        end

        assign rdata[k*DW +: DW] = rd;
        // A write landing this cycle retires the pending load for that reader.
        assign rbusy[k] = rst_n && busy[ra] && !hit0 && !hit1 &&
                          (ra != AW'(REG_ZERO));
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: driver pushes expected reads, monitor compares mid-cycle.
module tb_regfile_sb;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int W   = 4 + 2*DW + NRD + 1;

    logic              clk;
    logic              rst_n;
    logic              wen0;
    logic [AW-1:0]     waddr0;
    logic [DW-1:0]     wdata0;
    logic              wen1;
    logic [AW-1:0]     waddr1;
    logic [DW-1:0]     wdata1;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic              bset;
    logic [AW-1:0]     baddr;
    logic              any_busy;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           errors;

    regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen0     (wen0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .wen1     (wen1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .bset     (bset),
        .baddr    (baddr),
        .any_busy (any_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic idle();
        wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
        wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
        bset = 1'b0; baddr = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    // mask bits: [3]=rdata0 [2]=rdata1 [1]=rbusy [0]=any_busy
    task automatic expect_rd(input string nm, input logic [3:0] m,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic [NRD-1:0] rb, input logic ab);
        exp_q.push_back({m, d0, d1, rb, ab});
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: inputs settle at posedge+1, outputs compared at negedge
    always @(negedge clk) begin
        logic [W-1:0]   e;
        string          nm;
        logic [3:0]     m;
        logic [DW-1:0]  d0, d1;
        logic [NRD-1:0] rb;
        logic           ab;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            {m, d0, d1, rb, ab} = e;
            if (m[3]) begin
                checks++;
                if (rdata[DW-1:0] !== d0) begin
                    errors++;
                    $display("FAIL %s rdata0: got %h expected %h", nm, rdata[DW-1:0], d0);
                end
            end
            if (m[2]) begin
                checks++;
                if (rdata[2*DW-1:DW] !== d1) begin
                    errors++;
                    $display("FAIL %s rdata1: got %h expected %h", nm, rdata[2*DW-1:DW], d1);
                end
            end
            if (m[1]) begin
                checks++;
                if (rbusy !== rb) begin
                    errors++;
                    $display("FAIL %s rbusy: got %b expected %b", nm, rbusy, rb);
                end
            end
            if (m[0]) begin
                checks++;
                if (any_busy !== ab) begin
                    errors++;
                    $display("FAIL %s any_busy: got %b expected %b", nm, any_busy, ab);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        rd(5'd0, 5'd1);
        step();

        // held in reset with a write attempt: no bypass, nothing busy
        wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'hCAFE_0001;
        expect_rd("in_reset", 4'hF, 32'h0, 32'h0, 2'b00, 1'b0);
        step();
        idle();
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            expect_rd("reset_sweep", 4'hF, 32'h0, 32'h0, 2'b00, 1'b0);
            step();
        end

        // port 0 write with same-cycle bypass, then persistence
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234_5678;
        rd(5'd5, 5'd0);
        expect_rd("w0_bypass", 4'hF, 32'h1234_5678, 32'h0, 2'b00, 1'b0);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            rd(5'd0, 5'd5);
            expect_rd("w0_stored", 4'hF, 32'h0, 32'h1234_5678, 2'b00, 1'b0);
            step();
        end

        // dual write collision: port 1 wins
        wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA_AAAA;
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555_5555;
        rd(5'd7, 5'd5);
        expect_rd("collide_byp", 4'hF, 32'h5555_5555, 32'h1234_5678, 2'b00, 1'b0);
        step();
        idle();
        rd(5'd7, 5'd7);
        expect_rd("collide_st", 4'hF, 32'h5555_5555, 32'h5555_5555, 2'b00, 1'b0);
        step();

        // port 0 only bypass on read port 1
        wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h0BAD_F00D;
        rd(5'd7, 5'd12);
        expect_rd("w0_byp_p1", 4'hF, 32'h5555_5555, 32'h0BAD_F00D, 2'b00, 1'b0);
        step();
        idle();

        // address 0 ignores writes and bset
        wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
        bset = 1'b1; baddr = 5'd0;
        rd(5'd0, 5'd7);
        expect_rd("zero_wr", 4'hF, 32'h0, 32'h5555_5555, 2'b00, 1'b0);
        step();
        idle();
        rd(5'd0, 5'd12);
        expect_rd("zero_after", 4'hF, 32'h0, 32'h0BAD_F00D, 2'b00, 1'b0);
        step();

        // scoreboard set / clear
        bset = 1'b1; baddr = 5'd9;
        rd(5'd9, 5'd0);
        expect_rd("bset9", 4'hF, 32'h0, 32'h0, 2'b00, 1'b0);
        step();
        idle();
        rd(5'd9, 5'd9);
        expect_rd("busy9", 4'hF, 32'h0, 32'h0, 2'b11, 1'b1);
        step();
        wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000_0099;
        expect_rd("retire9", 4'hF, 32'h99, 32'h99, 2'b00, 1'b1);
        step();
        idle();
        expect_rd("clear9", 4'hF, 32'h99, 32'h99, 2'b00, 1'b0);
        step();
        bset = 1'b1; baddr = 5'd9;
        step();
        idle();
        expect_rd("rebusy9", 4'h3, 32'h0, 32'h0, 2'b11, 1'b1);
        step();
        bset = 1'b1; baddr = 5'd9;
        wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000_00AB;
        rd(5'd9, 5'd5);
        expect_rd("set_and_wr", 4'hF, 32'hAB, 32'h1234_5678, 2'b00, 1'b1);
        step();
        idle();
        expect_rd("set_wins", 4'hF, 32'hAB, 32'h1234_5678, 2'b01, 1'b1);
        step();
        wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h0000_0011;
        expect_rd("retire9_w0", 4'hF, 32'h11, 32'h1234_5678, 2'b00, 1'b1);
        step();
        idle();
        expect_rd("clear9_w0", 4'hF, 32'h11, 32'h1234_5678, 2'b00, 1'b0);
        step();

        // reset mid-operation
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEAD_BEEF;
        bset = 1'b1; baddr = 5'd4;
        rd(5'd3, 5'd4);
        expect_rd("pre_rst", 4'hF, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0);
        step();
        idle();
        rst_n = 1'b0;
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h0000_0077;
        bset = 1'b1; baddr = 5'd6;
        expect_rd("rst_cycle", 4'hF, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0);
        step();
        idle();
        rst_n = 1'b1;
        rd(5'd3, 5'd4);
        expect_rd("post_rst", 4'hF, 32'h0, 32'h0, 2'b00, 1'b0);
        step();
        rd(5'd6, 5'd5);
        expect_rd("post_rst2", 4'hF, 32'h0, 32'h0, 2'b00, 1'b0);
        step();
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h0000_0042;
        bset = 1'b1; baddr = 5'd4;
        rd(5'd3, 5'd4);
        expect_rd("post_rst_wr", 4'hF, 32'h42, 32'h0, 2'b00, 1'b0);
        step();
        idle();
        expect_rd("post_rst_sb", 4'hF, 32'h42, 32'h0, 2'b10, 1'b1);
        step();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
